// File: rtl/nem_ohmux_pkg.sv
// Shared types and helpers for the break-before-make NEM one-hot inverting mux.
// Imported by the request checker and the sequencing top.
package nem_ohmux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StMake
    } state_e;

    // Widest select vector the one-hot helper handles; NUM_IN must not exceed this.
    localparam int unsigned MaxIn = 64;

    function automatic int unsigned cnt_width(input int unsigned t_break,
                                              input int unsigned t_make);
        int unsigned longest;
        longest = (t_break > t_make) ? t_break : t_make;
        return $clog2(longest + 1);
    endfunction

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    function automatic logic onehot_chk(input logic [MaxIn-1:0] vec);
        return (vec != '0) && ((vec & (vec - MaxIn'(1))) == '0);
    endfunction

endpackage

// File: rtl/nem_ohmux_onehot_chk.sv
// Combinational validation of a select request: flags exactly-one-hot and all-zero.
// Used by the sequencer to drop malformed requests before they reach the relays.
module nem_ohmux_onehot_chk
    import nem_ohmux_pkg::*;
#(
    parameter int unsigned NUM_IN = 4
) (
    input  logic [NUM_IN-1:0] req,
    output logic              is_onehot,
    output logic              is_zero
);

    logic [MaxIn-1:0] req_ext;

    assign req_ext   = MaxIn'(req);
    assign is_onehot = onehot_chk(req_ext);
    assign is_zero   = (req == '0);

endmodule

// File: rtl/nem_ohmux_bbm_seq.sv
// Parametrised NEM one-hot inverting mux with break-before-make relay sequencing.
// A new select opens every relay for T_BREAK cycles, closes the new one, then settles for T_MAKE.
module nem_ohmux_bbm_seq
    import nem_ohmux_pkg::*;
#(
    parameter int unsigned NUM_IN  = 4,
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned T_BREAK = 2,
    parameter int unsigned T_MAKE  = 3
) (
    input  logic                    CP,
    input  logic                    CDN,
    input  logic [NUM_IN*WIDTH-1:0] I,
    input  logic [NUM_IN-1:0]       SEL_REQ,
    input  logic                    SEL_VALID,
    output logic                    SEL_READY,
    output logic [NUM_IN-1:0]       S,
    output logic [WIDTH-1:0]        ZN,
    output logic                    SETTLED,
    output logic                    SEL_ERR
);

    localparam int unsigned CW = cnt_width(T_BREAK, T_MAKE);
    localparam logic [CW-1:0] BreakLoad = CW'(T_BREAK - 1);
    localparam logic [CW-1:0] MakeLoad  = CW'(T_MAKE - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_IN-1:0]   pend_q, pend_d;
    logic [NUM_IN-1:0]   s_q, s_d;
    logic [WIDTH-1:0]    zn_q, zn_d;
    logic                settled_q, settled_d;
    logic                err_q, err_d;

    logic                req_onehot;
    logic                req_zero;
    logic                req_bad;
    logic                accept;
    logic [WIDTH-1:0]    or_acc;

    nem_ohmux_onehot_chk #(
        .NUM_IN (NUM_IN)
    ) u_onehot_chk (
        .req       (SEL_REQ),
        .is_onehot (req_onehot),
        .is_zero   (req_zero)
    );

    assign req_bad   = req_zero | ~req_onehot;
    assign SEL_READY = (state_q == StIdle);
    assign accept    = SEL_VALID & SEL_READY;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        s_d       = s_q;
        settled_d = settled_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (SEL_REQ != s_q) begin
                        // Open every relay first; the new one closes only after release.
                        s_d       = '0;
                        settled_d = 1'b0;
                        pend_d    = SEL_REQ;
                        cnt_d     = BreakLoad;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                if (cnt_q == '0) begin
                    s_d     = pend_q;
                    cnt_d   = MakeLoad;
                    state_d = StMake;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StMake: begin
                if (cnt_q == '0) begin
                    settled_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                s_d     = '0;
                state_d = StIdle;
            end
        endcase
    end

    // The output register sees the select value being loaded this edge, so ZN never lags S.
    always_comb begin
        or_acc = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (s_d[k]) begin
                or_acc = or_acc | I[k*WIDTH +: WIDTH];
            end
        end
        zn_d = ~or_acc;
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_q    <= '0;
            s_q       <= '0;
            zn_q      <= '1;
            settled_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            s_q       <= s_d;
            zn_q      <= zn_d;
            settled_q <= settled_d;
            err_q     <= err_d;
        end
    end

    assign S       = s_q;
    assign ZN      = zn_q;
    assign SETTLED = settled_q;
    assign SEL_ERR = err_q;

endmodule

// File: tb/tb_nem_ohmux_bbm_seq.sv
// Directed bench for nem_ohmux_bbm_seq: a default 4x1 instance and an 8x8 instance
// for the asynchronous reset-in-MAKE scenario.
module tb_nem_ohmux_bbm_seq;

    logic cp = 1'b0;
    always #5 cp = ~cp;

    int checks   = 0;
    int failures = 0;

    logic       cdn4;
    logic [3:0] i4, req4, s4;
    logic       val4, rdy4, set4, err4;
    logic [0:0] zn4;

    logic        cdn8;
    logic [63:0] i8;
    logic [7:0]  req8, s8, zn8;
    logic        val8, rdy8, set8, err8;

    nem_ohmux_bbm_seq #(
        .NUM_IN  (4),
        .WIDTH   (1),
        .T_BREAK (2),
        .T_MAKE  (3)
    ) dut4 (
        .CP        (cp),
        .CDN       (cdn4),
        .I         (i4),
        .SEL_REQ   (req4),
        .SEL_VALID (val4),
        .SEL_READY (rdy4),
        .S         (s4),
        .ZN        (zn4),
        .SETTLED   (set4),
        .SEL_ERR   (err4)
    );

    nem_ohmux_bbm_seq #(
        .NUM_IN  (8),
        .WIDTH   (8),
        .T_BREAK (2),
        .T_MAKE  (3)
    ) dut8 (
        .CP        (cp),
        .CDN       (cdn8),
        .I         (i8),
        .SEL_REQ   (req8),
        .SEL_VALID (val8),
        .SEL_READY (rdy8),
        .S         (s8),
        .ZN        (zn8),
        .SETTLED   (set8),
        .SEL_ERR   (err8)
    );

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic test_reset();
        cdn4 = 1'b0; cdn8 = 1'b0;
        i4 = '0; req4 = '0; val4 = 1'b0;
        i8 = '0; req8 = '0; val8 = 1'b0;
        tick(); tick();
        cdn4 = 1'b1; cdn8 = 1'b1;
        tick();
        checks++; if (s4 !== 4'b0000) begin failures++; $display("FAIL rst_s4 got=%b want=0000", s4); end
        checks++; if (zn4 !== 1'b1) begin failures++; $display("FAIL rst_zn4 got=%b want=1", zn4); end
        checks++; if (set4 !== 1'b1) begin failures++; $display("FAIL rst_settled got=%b want=1", set4); end
        checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want=1", rdy4); end
        checks++; if (err4 !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", err4); end
        checks++; if (s8 !== 8'h00) begin failures++; $display("FAIL rst_s8 got=%h want=00", s8); end
        checks++; if (zn8 !== 8'hFF) begin failures++; $display("FAIL rst_zn8 got=%h want=ff", zn8); end
    endtask

    task automatic test_switch();
        i4 = 4'b0010; req4 = 4'b0010; val4 = 1'b1;
        tick(); // E0
        val4 = 1'b0;
        checks++; if (s4 !== 4'b0000) begin failures++; $display("FAIL sw_e0_s got=%b want=0000", s4); end
        checks++; if (set4 !== 1'b0) begin failures++; $display("FAIL sw_e0_settled got=%b want=0", set4); end
        checks++; if (zn4 !== 1'b1) begin failures++; $display("FAIL sw_e0_zn got=%b want=1", zn4); end
        tick(); // E0+1
        checks++; if (s4 !== 4'b0000) begin failures++; $display("FAIL sw_e1_s got=%b want=0000", s4); end
        checks++; if (zn4 !== 1'b1) begin failures++; $display("FAIL sw_e1_zn got=%b want=1", zn4); end
        checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL sw_e1_ready got=%b want=0", rdy4); end
        tick(); // E0+2
        checks++; if (s4 !== 4'b0010) begin failures++; $display("FAIL sw_e2_s got=%b want=0010", s4); end
        checks++; if (zn4 !== 1'b0) begin failures++; $display("FAIL sw_e2_zn got=%b want=0", zn4); end
        checks++; if (set4 !== 1'b0) begin failures++; $display("FAIL sw_e2_settled got=%b want=0", set4); end
        tick(); tick(); // E0+4
        checks++; if (set4 !== 1'b0) begin failures++; $display("FAIL sw_e4_settled got=%b want=0", set4); end
        checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL sw_e4_ready got=%b want=0", rdy4); end
        tick(); // E0+5
        checks++; if (set4 !== 1'b1) begin failures++; $display("FAIL sw_e5_settled got=%b want=1", set4); end
        checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL sw_e5_ready got=%b want=1", rdy4); end
    endtask

    task automatic test_same_select();
        req4 = 4'b0010; val4 = 1'b1;
        tick();
        val4 = 1'b0;
        checks++; if (s4 !== 4'b0010) begin failures++; $display("FAIL same_s got=%b want=0010", s4); end
        checks++; if (set4 !== 1'b1) begin failures++; $display("FAIL same_settled got=%b want=1", set4); end
        checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL same_ready got=%b want=1", rdy4); end
        checks++; if (zn4 !== 1'b0) begin failures++; $display("FAIL same_zn got=%b want=0", zn4); end
        i4 = 4'b0000;
        #1;
        checks++; if (zn4 !== 1'b0) begin failures++; $display("FAIL zn_not_comb got=%b want=0", zn4); end
        tick();
        checks++; if (zn4 !== 1'b1) begin failures++; $display("FAIL zn_latency got=%b want=1", zn4); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_s   [8] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000,
                                    4'b1000, 4'b1000, 4'b1000, 4'b1000};
        logic       exp_rdy [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_set [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_zn  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        i4 = 4'b1000; req4 = 4'b1000; val4 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if (s4 !== exp_s[c]) begin
                failures++; $display("FAIL held_s cyc=%0d got=%b want=%b", c, s4, exp_s[c]);
            end
            checks++;
            if (rdy4 !== exp_rdy[c]) begin
                failures++; $display("FAIL held_ready cyc=%0d got=%b want=%b", c, rdy4, exp_rdy[c]);
            end
            checks++;
            if (set4 !== exp_set[c]) begin
                failures++; $display("FAIL held_settled cyc=%0d got=%b want=%b", c, set4, exp_set[c]);
            end
            checks++;
            if (zn4 !== exp_zn[c]) begin
                failures++; $display("FAIL held_zn cyc=%0d got=%b want=%b", c, zn4, exp_zn[c]);
            end
        end
        val4 = 1'b0;
    endtask

    task automatic test_invalid();
        req4 = 4'b0110; val4 = 1'b1;
        tick();
        checks++; if (err4 !== 1'b1) begin failures++; $display("FAIL multi_err got=%b want=1", err4); end
        checks++; if (s4 !== 4'b1000) begin failures++; $display("FAIL multi_s got=%b want=1000", s4); end
        checks++; if (set4 !== 1'b1) begin failures++; $display("FAIL multi_settled got=%b want=1", set4); end
        req4 = 4'b0000;
        tick();
        checks++; if (s4 !== 4'b1000) begin failures++; $display("FAIL zero_s got=%b want=1000", s4); end
        checks++; if (rdy4 !== 1'b1) begin failures++; $display("FAIL zero_ready got=%b want=1", rdy4); end
        val4 = 1'b0;
        tick(); tick();
        checks++; if (err4 !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err4); end
        checks++; if (set4 !== 1'b1) begin failures++; $display("FAIL zero_settled got=%b want=1", set4); end
    endtask

    task automatic test_reset_in_make();
        i8 = 64'h8877_6655_4433_2211;
        req8 = 8'h04; val8 = 1'b1;
        tick(); // E0
        val8 = 1'b0;
        checks++; if (zn8 !== 8'hFF) begin failures++; $display("FAIL w8_e0_zn got=%h want=ff", zn8); end
        tick(); tick(); // E0+2
        checks++; if (s8 !== 8'h04) begin failures++; $display("FAIL w8_e2_s got=%h want=04", s8); end
        checks++; if (zn8 !== 8'hCC) begin failures++; $display("FAIL w8_e2_zn got=%h want=cc", zn8); end
        tick(); // E0+3, inside MAKE
        #2;
        cdn8 = 1'b0;
        #1;
        checks++; if (s8 !== 8'h00) begin failures++; $display("FAIL async_s got=%h want=00", s8); end
        checks++; if (zn8 !== 8'hFF) begin failures++; $display("FAIL async_zn got=%h want=ff", zn8); end
        checks++; if (set8 !== 1'b1) begin failures++; $display("FAIL async_settled got=%b want=1", set8); end
        checks++; if (rdy8 !== 1'b1) begin failures++; $display("FAIL async_ready got=%b want=1", rdy8); end
        tick();
        cdn8 = 1'b1;
        tick();
        checks++; if (s8 !== 8'h00) begin failures++; $display("FAIL post_rst_s got=%h want=00", s8); end
        req8 = 8'h80; val8 = 1'b1;
        tick(); // E0
        val8 = 1'b0;
        tick(); // E0+1
        checks++; if (zn8 !== 8'hFF) begin failures++; $display("FAIL w8b_e1_zn got=%h want=ff", zn8); end
        tick(); // E0+2
        checks++; if (s8 !== 8'h80) begin failures++; $display("FAIL w8b_e2_s got=%h want=80", s8); end
        checks++; if (zn8 !== 8'h77) begin failures++; $display("FAIL w8b_e2_zn got=%h want=77", zn8); end
        i8[63:56] = 8'h5A;
        tick(); // E0+3
        checks++; if (zn8 !== 8'hA5) begin failures++; $display("FAIL w8_track got=%h want=a5", zn8); end
        i8[7:0] = 8'hFF;
        tick(); // E0+4
        checks++; if (zn8 !== 8'hA5) begin failures++; $display("FAIL w8_unsel got=%h want=a5", zn8); end
        checks++; if (set8 !== 1'b0) begin failures++; $display("FAIL w8_e4_settled got=%b want=0", set8); end
        tick(); // E0+5
        checks++; if (set8 !== 1'b1) begin failures++; $display("FAIL w8_e5_settled got=%b want=1", set8); end
        checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL w8_err got=%b want=0", err8); end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_same_select();
        test_back_to_back();
        test_invalid();
        test_reset_in_make();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nem_ohmux_bbm_seq.md
Name: nem_ohmux_bbm_seq

Overview:
Parametrised successor of the 4-input, 1-bit NEM one-hot inverting mux. Supports NUM_IN inputs of WIDTH bits each and a registered output. The added sequencing is break-before-make relay actuation: a new one-hot select request opens all relays, waits for mechanical release, closes the new relay, then waits for contact settling. Sits between routing-config logic and NEM crossbar datapaths; the settling counts model relay mechanical delay in RTL.

Parameters:
NUM_IN, 4, number of mux inputs / select lines (>=2)
WIDTH, 1, bits per input channel (>=1)
T_BREAK, 2, cycles all selects held low before closing the new one (>=1)
T_MAKE, 3, cycles after closing before SETTLED asserts (>=1)

Ports:
CP  input  1  clock, rising edge
CDN  input  1  asynchronous active-low reset
I  input  NUM_IN*WIDTH  data; channel k = I[k*WIDTH +: WIDTH]
SEL_REQ  input  NUM_IN  requested one-hot select
SEL_VALID  input  1  request valid
SEL_READY  output  1  block accepts a request
S  output  NUM_IN  actuated select state (relay drive), registered
ZN  output  WIDTH  registered inverted mux result
SETTLED  output  1  S stable and contacts settled
SEL_ERR  output  1  sticky: non-one-hot request seen

Behaviour:
- Clock and reset: one clock CP. CDN is asynchronous, active-low; clear on CDN low, release synchronous to CP.
- Reset values: S=0, ZN=all ones, SETTLED=1, SEL_READY=1, SEL_ERR=0, state IDLE.
- Reset mid-transition: all relays open immediately (S=0).
- States: IDLE, BREAK, MAKE.
- Accept: a request is accepted on a CP edge with SEL_VALID & SEL_READY. SEL_READY=1 only in IDLE.
- Invalid request: an accepted SEL_REQ with zero or more than one bit set is dropped. SEL_ERR sets (sticky until reset). S and state are unchanged.
- Same select: a valid SEL_REQ equal to current S is accepted as a no-op. State stays IDLE; no glitch on S or SETTLED.
- IDLE->BREAK: on acceptance of a valid, different select at edge E0. At E0: S<=0, SETTLED<=0, latch SEL_REQ to pend, counter<=T_BREAK-1.
- BREAK: counter decrements each edge. At edge E0+T_BREAK: S<=pend, go to MAKE, counter<=T_MAKE-1.
- MAKE: counter decrements each edge. At edge E0+T_BREAK+T_MAKE: SETTLED<=1, go to IDLE (SEL_READY=1).
- Timing: total transition is T_BREAK+T_MAKE cycles. S is never multi-hot at any time.
- ZN update: every edge, ZN <= ~(OR over k of (S_next[k] ? I_k : 0)), where S_next is the value S takes at that edge. Latency I->ZN is 1 cycle.
- S=0 gives ZN=all ones, including during BREAK.
- SEL_VALID held during BREAK/MAKE: no acceptance. The request is re-evaluated in IDLE.
- Counter width: $clog2(max(T_BREAK,T_MAKE)+1). No wrap; the counter saturates at 0 only on exit.

Decomposition:
- Package nem_ohmux_pkg: state typedef (IDLE/BREAK/MAKE), the counter-width function, and a one-hot check function.
- Sub-module nem_ohmux_onehot_chk: combinational, NUM_IN-wide. Outputs is_onehot and is_zero, used for request validation.
- AND-OR-invert datapath and FSM stay in the top.

Test Plan:
1. Reset release (NUM_IN=4, WIDTH=1, T_BREAK=2, T_MAKE=3) -> S=0000, ZN=1, SETTLED=1, SEL_READY=1, SEL_ERR=0.
2. Accept SEL_REQ=0010 at E0, I1=1 -> S=0000 at E0, E0+1; S=0010 at E0+2; ZN=1 through E0+1, ZN=0 at E0+2; SETTLED=1 and SEL_READY=1 at E0+5.
3. From S=0010, request 1000 at E0 with SEL_VALID held high -> S never multi-hot; SEL_READY low E0..E0+4; no second accept of the held request is a no-op duplicate beyond one (held 1000 re-accepted as no-op at E0+5).
4. Request 0110, then 0000 -> each accepted and dropped; SEL_ERR=1 sticky; S and SETTLED unchanged.
5. Request equal to current S (0010) -> accepted in 1 cycle; S, SETTLED, ZN unchanged.
6. CDN pulse low during MAKE, with WIDTH=8, NUM_IN=8 and random I -> S=0 and ZN=8'hFF immediately (asynchronously). After release, ZN tracks ~I_k one cycle after S selects channel k.
